// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 nonce sweep: FSM state encoding,
// the FIPS 180-4 initial hash value, datapath widths and padding lengths.
package sha256_pkg;

  localparam int HEADER_W = 640;
  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;

  // Message bit lengths written into the final 64 bits of each padded block.
  localparam logic [63:0] HDR_BIT_LEN    = 64'd640;
  localparam logic [63:0] DIGEST_BIT_LEN = 64'd256;

  localparam logic [DIGEST_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_H2,
    ST_CMP,
    ST_REPORT,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/sha256_block_pad.sv
// Forms the padded second header block (tail + nonce) and the padded block
// for the outer hash of the 256-bit first digest.
module sha256_block_pad
  import sha256_pkg::*;
(
  input  logic [95:0]         header_tail,
  input  logic [NONCE_W-1:0]  nonce,
  input  logic [DIGEST_W-1:0] h1,
  output logic [BLOCK_W-1:0]  blk1,
  output logic [BLOCK_W-1:0]  blk2
);

  assign blk1 = {header_tail, nonce, 1'b1, 319'b0, HDR_BIT_LEN};
  assign blk2 = {h1, 1'b1, 191'b0, DIGEST_BIT_LEN};

endmodule

// File: rtl/sha256_nonce_scheduler.sv
// Drives a shared sha256 core through a double-SHA-256 nonce sweep and reports
// digests below target. Define MIDSTATE_CACHE_EN to hash header block 0 once per job.
module sha256_nonce_scheduler
  import sha256_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [HEADER_W-1:0]  job_header,
  input  logic [DIGEST_W-1:0]  job_target,
  input  logic [NONCE_W-1:0]   job_nonce_start,
  input  logic [NONCE_W-1:0]   job_nonce_end,
  input  logic                 abort,
  output logic                 core_start,
  output logic [BLOCK_W-1:0]   core_block,
  output logic [DIGEST_W-1:0]  core_iv,
  output logic                 core_use_std_iv,
  input  logic                 core_done,
  input  logic [DIGEST_W-1:0]  core_digest,
  output logic                 found_valid,
  input  logic                 found_ready,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic [DIGEST_W-1:0]  found_hash,
  output logic                 busy,
  output logic                 exhausted,
  output logic [COUNT_W-1:0]   nonce_count
);

  state_t              state;
  logic [HEADER_W-33:0] hdr_q;      // header[639:32]; the nonce field is never needed
  logic [DIGEST_W-1:0] target_q;
  logic [NONCE_W-1:0]  nonce;
  logic [NONCE_W-1:0]  nonce_end;
  logic [DIGEST_W-1:0] midstate;
  logic [DIGEST_W-1:0] h2;

  logic [NONCE_W-1:0]  pad_nonce;
  logic [BLOCK_W-1:0]  blk1;
  logic [BLOCK_W-1:0]  blk2;
  logic                unused_nonce_field;

  assign unused_nonce_field = ^job_header[NONCE_W-1:0];

  // Leaving NEXT loads the H1 block for the following nonce in the same edge.
  assign pad_nonce = (state == ST_NEXT) ? nonce + 32'd1 : nonce;
  assign core_iv   = midstate;

  sha256_block_pad u_pad (
    .header_tail (hdr_q[95:0]),
    .nonce       (pad_nonce),
    .h1          (core_digest),
    .blk1        (blk1),
    .blk2        (blk2)
  );

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge state; blocking assignments would make results order-dependent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      job_ready       <= 1'b1;
      busy            <= 1'b0;
      core_start      <= 1'b0;
      core_block      <= '0;
      core_use_std_iv <= 1'b1;
      midstate        <= '0;
      found_valid     <= 1'b0;
      found_nonce     <= '0;
      found_hash      <= '0;
      exhausted       <= 1'b0;
      nonce_count     <= '0;
      hdr_q           <= '0;
      target_q        <= '0;
      nonce           <= '0;
      nonce_end       <= '0;
      h2              <= '0;
    end else begin
      core_start <= 1'b0;
      exhausted  <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state       <= ST_IDLE;
        job_ready   <= 1'b1;
        busy        <= 1'b0;
        found_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (job_valid && job_ready && !abort) begin
              hdr_q           <= job_header[HEADER_W-1:NONCE_W];
              target_q        <= job_target;
              nonce           <= job_nonce_start;
              nonce_end       <= job_nonce_end;
              nonce_count     <= '0;
              job_ready       <= 1'b0;
              busy            <= 1'b1;
              state           <= ST_H0;
              core_start      <= 1'b1;
              core_block      <= job_header[HEADER_W-1:128];
              core_use_std_iv <= 1'b1;
            end
          end
          ST_H0: begin
            if (core_done) begin
              midstate        <= core_digest;
              state           <= ST_H1;
              core_start      <= 1'b1;
              core_block      <= blk1;
              core_use_std_iv <= 1'b0;
            end
          end
          ST_H1: begin
            if (core_done) begin
              state           <= ST_H2;
              core_start      <= 1'b1;
              core_block      <= blk2;
              core_use_std_iv <= 1'b1;
            end
          end
          ST_H2: begin
            if (core_done) begin
              h2    <= core_digest;
              state <= ST_CMP;
            end
          end
          ST_CMP: begin
            if (h2 < target_q) begin
              found_valid <= 1'b1;
              found_nonce <= nonce;
              found_hash  <= h2;
              state       <= ST_REPORT;
            end else begin
              state <= ST_NEXT;
            end
          end
          ST_REPORT: begin
            if (found_ready) begin
              found_valid <= 1'b0;
              state       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (nonce_count != '1) nonce_count <= nonce_count + 1'b1;
            if (nonce == nonce_end) begin
              exhausted <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              nonce      <= nonce + 32'd1;
              core_start <= 1'b1;
`ifdef MIDSTATE_CACHE_EN
              state           <= ST_H1;
              core_block      <= blk1;
              core_use_std_iv <= 1'b0;
`else
              state           <= ST_H0;
              core_block      <= hdr_q[HEADER_W-33:96];
              core_use_std_iv <= 1'b1;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Directed bench for sha256_nonce_scheduler with a fixed-latency (L=4) core model
// whose digest is a simple keyed mix of block and IV.
module tb_sha256_nonce_scheduler;

  localparam int L = 4;
  localparam logic [255:0] STD_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ONES = {256{1'b1}};
`ifdef MIDSTATE_CACHE_EN
  localparam int STARTS_3 = 7;
  localparam int STARTS_4 = 9;
  localparam int BUSY_4   = 53;
`else
  localparam int STARTS_3 = 9;
  localparam int STARTS_4 = 12;
  localparam int BUSY_4   = 68;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid;
  logic         job_ready;
  logic [639:0] job_header;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_nonce_end;
  logic         abort;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_iv;
  logic         core_use_std_iv;
  logic         core_done;
  logic [255:0] core_digest;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         busy;
  logic         exhausted;
  logic [31:0]  nonce_count;

  logic [639:0] hdr;
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_exh    = 0;
  int n_busy   = 0;
  int n_done   = 0;
  int n_unstable = 0;
  logic [31:0]  fnonce[$];
  logic [255:0] fhash[$];

  always #5 clk = ~clk;

  sha256_nonce_scheduler #(.COUNT_W(32)) dut (
    .clk (clk), .reset (reset),
    .job_valid (job_valid), .job_ready (job_ready), .job_header (job_header),
    .job_target (job_target), .job_nonce_start (job_nonce_start),
    .job_nonce_end (job_nonce_end), .abort (abort),
    .core_start (core_start), .core_block (core_block), .core_iv (core_iv),
    .core_use_std_iv (core_use_std_iv), .core_done (core_done),
    .core_digest (core_digest), .found_valid (found_valid),
    .found_ready (found_ready), .found_nonce (found_nonce),
    .found_hash (found_hash), .busy (busy), .exhausted (exhausted),
    .nonce_count (nonce_count)
  );

  function automatic logic [255:0] dig(input logic [511:0] b, input logic [255:0] iv);
    logic [255:0] x;
    x = (iv + b[511:256]) ^ {b[254:0], b[255]};
    return x ^ {x[191:0], x[255:192]} ^ 256'h5a;
  endfunction

  function automatic logic [255:0] exp_h2(input logic [31:0] n);
    logic [255:0] mid;
    logic [255:0] h1;
    mid = dig(hdr[639:128], STD_IV);
    h1  = dig({hdr[127:32], n, 1'b1, 319'b0, 64'd640}, mid);
    return dig({h1, 1'b1, 191'b0, 64'd256}, STD_IV);
  endfunction

  // Core model: done is high L cycles after the cycle in which start is high.
  logic [2:0]   cnt;
  logic [511:0] cap_block;
  logic [255:0] cap_iv;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      core_done   <= 1'b0;
      core_digest <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        cnt       <= 3'(L - 1);
        cap_block <= core_block;
        cap_iv    <= core_use_std_iv ? STD_IV : core_iv;
      end else if (cnt != 0) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          core_done   <= 1'b1;
          core_digest <= dig(cap_block, cap_iv);
          if (core_block !== cap_block || (!core_use_std_iv && core_iv !== cap_iv))
            n_unstable <= n_unstable + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (core_start) n_starts <= n_starts + 1;
    if (exhausted)  n_exh    <= n_exh + 1;
    if (busy)       n_busy   <= n_busy + 1;
    if (core_done)  n_done   <= n_done + 1;
    if (found_valid && found_ready) begin
      fnonce.push_back(found_nonce);
      fhash.push_back(found_hash);
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t);
    @(posedge clk); #1;
    job_valid = 1'b1; job_header = hdr; job_target = t;
    job_nonce_start = s; job_nonce_end = e;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check(tag, 256'(busy), 256'(0));
    @(negedge clk); #1;
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_ready"}, 256'(job_ready), 256'(1));
    check({tag, "_ctl"}, 256'({busy, core_start, found_valid, exhausted, core_use_std_iv}), 256'(5'b00001));
    check({tag, "_cnt"}, 256'(nonce_count), 256'(0));
    check({tag, "_block"}, core_block[511:256] | core_block[255:0], 256'(0));
    check({tag, "_iv"}, core_iv, 256'(0));
    check({tag, "_found"}, found_hash | 256'(found_nonce), 256'(0));
  endtask

  int b, e0, s0, bz0, d0, held;
  logic [31:0]  p_n;
  logic [255:0] p_h;

  initial begin
    for (int i = 0; i < 20; i++) hdr[i*32 +: 32] = 32'(i + 1) * 32'h9e3779b9;
    reset = 1'b1; job_valid = 1'b0; job_header = '0; job_target = '0;
    job_nonce_start = '0; job_nonce_end = '0; abort = 1'b0; found_ready = 1'b1;
    #12;
    reset_values("rst");
    #1 reset = 1'b0;
    @(negedge clk);
    reset_values("rst_rel");

    // All-ones target, 5..7: every nonce hits, in order.
    b = fnonce.size(); e0 = n_exh; s0 = n_starts;
    start_job(32'd5, 32'd7, ONES);
    wait_idle("t1_idle");
    check("t1_hits", 256'(fnonce.size() - b), 256'(3));
    for (int k = 0; k < 3; k++) begin
      if (fnonce.size() > b + k) begin
        check("t1_nonce", 256'(fnonce[b+k]), 256'(32'd5 + 32'(k)));
        check("t1_hash", fhash[b+k], exp_h2(32'd5 + 32'(k)));
      end
    end
    check("t1_exh", 256'(n_exh - e0), 256'(1));
    check("t1_count", 256'(nonce_count), 256'(3));
    check("t1_starts", 256'(n_starts - s0), 256'(STARTS_3));
    check("t1_ready", 256'(job_ready), 256'(1));

    // Zero target, 0..3: no hits; start count and sweep length.
    b = fnonce.size(); e0 = n_exh; s0 = n_starts; bz0 = n_busy;
    start_job(32'd0, 32'd3, 256'(0));
    wait_idle("t2_idle");
    check("t2_hits", 256'(fnonce.size() - b), 256'(0));
    check("t2_exh", 256'(n_exh - e0), 256'(1));
    check("t2_count", 256'(nonce_count), 256'(4));
    check("t2_starts", 256'(n_starts - s0), 256'(STARTS_4));
    check("t2_cycles", 256'(n_busy - bz0), 256'(BUSY_4));

    // Wrap-around sweep FFFFFFFF..1.
    b = fnonce.size(); e0 = n_exh;
    start_job(32'hFFFF_FFFF, 32'h1, ONES);
    wait_idle("t3_idle");
    check("t3_hits", 256'(fnonce.size() - b), 256'(3));
    if (fnonce.size() >= b + 3) begin
      check("t3_n0", 256'(fnonce[b]), 256'(32'hFFFF_FFFF));
      check("t3_n1", 256'(fnonce[b+1]), 256'(0));
      check("t3_n2", 256'(fnonce[b+2]), 256'(1));
      check("t3_h1", fhash[b+1], exp_h2(32'h0));
    end
    check("t3_exh", 256'(n_exh - e0), 256'(1));

    // Back-pressure: payload held, no core traffic during the stall.
    found_ready = 1'b0; e0 = n_exh;
    start_job(32'd9, 32'd9, ONES);
    held = 0;
    while (!found_valid && held < 200) begin
      @(negedge clk);
      held++;
    end
    check("t4_valid", 256'(found_valid), 256'(1));
    p_n = found_nonce; p_h = found_hash; s0 = n_starts; held = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (found_valid && found_nonce === p_n && found_hash === p_h) held++;
    end
    check("t4_held", 256'(held), 256'(10));
    check("t4_nostart", 256'(n_starts - s0), 256'(0));
    check("t4_nonce", 256'(p_n), 256'(9));
    check("t4_hash", p_h, exp_h2(32'd9));
    @(posedge clk); #1 found_ready = 1'b1;
    wait_idle("t4_idle");
    check("t4_exh", 256'(n_exh - e0), 256'(1));
    check("t4_count", 256'(nonce_count), 256'(1));

    // Abort in IDLE blocks the job.
    @(posedge clk); #1;
    abort = 1'b1; job_valid = 1'b1; job_nonce_start = 0; job_nonce_end = 0;
    @(posedge clk); #1;
    abort = 1'b0; job_valid = 1'b0;
    @(negedge clk);
    check("t5_idle_abort", 256'({busy, job_ready}), 256'(2'b01));

    // Abort during H2, late core_done must be ignored.
    b = fnonce.size(); e0 = n_exh;
    start_job(32'd20, 32'd30, 256'(0));
    held = 0;
    while (!(core_start && core_use_std_iv && core_block[63:0] == 64'd256) && held < 200) begin
      @(negedge clk);
      held++;
    end
    check("t6_h2_seen", 256'(held < 200), 256'(1));
    d0 = n_done;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t6_aborted", 256'({busy, job_ready}), 256'(2'b01));
    repeat (6) @(negedge clk);
    #1;
    check("t6_late_done", 256'(n_done - d0), 256'(1));
    check("t6_still_idle", 256'({busy, job_ready, found_valid}), 256'(3'b010));
    check("t6_no_exh", 256'(n_exh - e0), 256'(0));
    check("t6_no_hit", 256'(fnonce.size() - b), 256'(0));

    // Asynchronous reset in H1, then a fresh job.
    start_job(32'd50, 32'd60, ONES);
    held = 0;
    while (!(core_start && !core_use_std_iv) && held < 200) begin
      @(negedge clk);
      held++;
    end
    check("t7_h1_seen", 256'(held < 200), 256'(1));
    #2 reset = 1'b1;
    #1 reset_values("t7_async");
    #3 reset = 1'b0;
    b = fnonce.size(); e0 = n_exh; s0 = n_starts;
    start_job(32'd3, 32'd3, ONES);
    wait_idle("t7_idle");
    check("t7_hits", 256'(fnonce.size() - b), 256'(1));
    if (fnonce.size() > b) begin
      check("t7_nonce", 256'(fnonce[b]), 256'(3));
      check("t7_hash", fhash[b], exp_h2(32'd3));
    end
    check("t7_starts", 256'(n_starts - s0), 256'(3));
    check("t7_exh", 256'(n_exh - e0), 256'(1));
    check("t7_count", 256'(nonce_count), 256'(1));
    check("stable_req", 256'(n_unstable), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
